// File: rtl/noc_out_port_arbiter.sv
// noc_out_port_arbiter: output-port switch allocator for one NoC router link.
// Round-robin head arbitration across N_REQ inputs (E/W/S/N/Local), wormhole
// locking until the tail flit, per-VC credit flow control, and a registered
// output flit stage.
// Optional define NOC_ARB_ERR_CHECK_EN: enables the sticky protocol-error flag
// (err). Without it, err is tied low and no check logic exists.

// Per-VC downstream credit counter. Starts full, never goes above VC_DEPTH.
module noc_arb_vc_credit #(
  parameter int VC_DEPTH = 4,
  parameter int CW       = $clog2(VC_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dec,
  input  logic          inc,
  output logic [CW-1:0] cnt
);
  // dec and inc together cancel; a credit at full is dropped
  always_ff @(posedge clk) begin
    if (rst)                                     cnt <= CW'(VC_DEPTH);
    else if (dec && !inc)                        cnt <= cnt - 1'b1;
    else if (inc && !dec && cnt != CW'(VC_DEPTH)) cnt <= cnt + 1'b1;
  end
endmodule

module noc_out_port_arbiter #(
  parameter int N_REQ    = 5,
  parameter int FLIT_W   = 64,
  parameter int NUM_VC   = 2,
  parameter int VC_DEPTH = 4,
  localparam int VCW     = $clog2(NUM_VC),
  localparam int CW      = $clog2(VC_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ-1:0]       req_head,
  input  logic [N_REQ-1:0]       req_tail,
  input  logic [N_REQ*VCW-1:0]   req_vc,
  input  logic [N_REQ*FLIT_W-1:0] req_flit,
  output logic [N_REQ-1:0]       gnt,
  input  logic [NUM_VC-1:0]      credit_in,
  output logic                   out_valid,
  output logic [VCW-1:0]         out_vc,
  output logic [FLIT_W-1:0]      out_flit,
  output logic [NUM_VC*CW-1:0]   credit_cnt,
  output logic                   locked,
  output logic                   err
);
  localparam int IW = $clog2(N_REQ);
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]                  state;
  logic [IW-1:0]               ptr, owner_idx, win;
  logic [VCW-1:0]              owner_vc, eff_vc;
  logic                        found;
  logic [N_REQ-1:0]            elig;
  logic [N_REQ-1:0][VCW-1:0]   vc_a;
  logic [NUM_VC-1:0][CW-1:0]   cnt_a;
  logic [NUM_VC-1:0]           cr_ok, dec_v;

  assign vc_a       = req_vc;
  assign credit_cnt = cnt_a;
  assign locked     = (state == LOCKED);

  noc_arb_vc_credit #(.VC_DEPTH(VC_DEPTH), .CW(CW)) u_cred [NUM_VC-1:0] (
    .clk (clk),
    .rst (rst),
    .dec (dec_v),
    .inc (credit_in),
    .cnt (cnt_a)
  );

  // eligibility: heads with credit when idle, only the owner when locked
  always_comb begin
    for (int v = 0; v < NUM_VC; v++) cr_ok[v] = (cnt_a[v] != '0);
    for (int i = 0; i < N_REQ; i++) begin
      if (state == IDLE) elig[i] = req_valid[i] & req_head[i] & cr_ok[vc_a[i]];
      else               elig[i] = (IW'(i) == owner_idx) & req_valid[i] & cr_ok[owner_vc];
    end
  end

  // rotating-priority search starting at the pointer
  always_comb begin
    int j;
    j     = 0;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && elig[j]) begin
        found = 1'b1;
        win   = IW'(j);
      end
    end
    gnt = '0;
    if (found) gnt[win] = 1'b1;
    eff_vc = (state == LOCKED) ? owner_vc : vc_a[win];
    for (int v = 0; v < NUM_VC; v++) dec_v[v] = found & (eff_vc == VCW'(v));
  end

  // ownership FSM and round-robin pointer (advances on head grants only)
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      owner_idx <= '0;
      owner_vc  <= '0;
    end else if (found) begin
      if (state == IDLE) begin
        ptr <= (win == IW'(N_REQ - 1)) ? '0 : win + 1'b1;
        if (!req_tail[win]) begin
          state     <= LOCKED;
          owner_idx <= win;
          owner_vc  <= vc_a[win];
        end
      end else if (req_tail[win]) begin
        state <= IDLE;
      end
    end
  end

  // registered link stage; payload holds when nothing transfers
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_vc    <= '0;
      out_flit  <= '0;
    end else begin
      out_valid <= found;
      if (found) begin
        out_vc   <= eff_vc;
        out_flit <= req_flit[win*FLIT_W +: FLIT_W];
      end
    end
  end

`ifdef NOC_ARB_ERR_CHECK_EN
  logic err_set;

  // protocol violations: credit overflow, idle body flits, owner misbehaviour
  always_comb begin
    err_set = 1'b0;
    for (int v = 0; v < NUM_VC; v++)
      if (credit_in[v] && cnt_a[v] == CW'(VC_DEPTH)) err_set = 1'b1;
    if (state == IDLE) err_set = err_set | (|(req_valid & ~req_head));
    else err_set = err_set | (req_valid[owner_idx] &
                              (req_head[owner_idx] | (vc_a[owner_idx] != owner_vc)));
  end

  // sticky until reset
  always_ff @(posedge clk) begin
    if (rst)          err <= 1'b0;
    else if (err_set) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_noc_out_port_arbiter.sv
// Directed bench for noc_out_port_arbiter: gnt/credits/lock checked inline,
// output flits checked by a scoreboard monitor on the falling edge.
module tb_noc_out_port_arbiter;
  localparam int N = 5, FW = 64, NV = 2, D = 4, VCW = 1, CW = 3;
`ifdef NOC_ARB_ERR_CHECK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]     req_valid, req_head, req_tail, gnt;
  logic [N*VCW-1:0] req_vc;
  logic [N*FW-1:0]  req_flit;
  logic [NV-1:0]    credit_in;
  logic             out_valid, locked, err;
  logic [VCW-1:0]   out_vc;
  logic [FW-1:0]    out_flit;
  logic [NV*CW-1:0] credit_cnt;

  typedef struct packed { logic [FW-1:0] flit; logic [VCW-1:0] vc; } exp_t;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0, seq = 0;
  logic [FW-1:0] w_flit;

  noc_out_port_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_head(req_head),
    .req_tail(req_tail), .req_vc(req_vc), .req_flit(req_flit), .gnt(gnt),
    .credit_in(credit_in), .out_valid(out_valid), .out_vc(out_vc),
    .out_flit(out_flit), .credit_cnt(credit_cnt), .locked(locked), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (out_valid === 1'b1) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL out_unexpected: got flit %0h with nothing expected", out_flit);
      end else begin
        e = q.pop_front();
        if (out_flit !== e.flit || out_vc !== e.vc) begin
          n_bad++;
          $display("FAIL out_flit: got %0h/vc%0d expected %0h/vc%0d",
                   out_flit, out_vc, e.flit, e.vc);
        end
      end
    end
  end

  function automatic logic [FW-1:0] flit_of(input int i, input int s);
    return {32'(i + 'hF0), 32'(s)};
  endfunction

  // drive one cycle, check gnt, queue the expected link flit
  task automatic step(input logic [4:0] v, h, t, vc, input logic [1:0] cr,
                      input logic [4:0] eg, input logic evc, input string nm);
    exp_t e;
    seq++;
    req_valid = v; req_head = h; req_tail = t; req_vc = vc; credit_in = cr;
    for (int i = 0; i < N; i++) req_flit[i*FW +: FW] = flit_of(i, seq);
    #1;
    chk(nm, 64'(gnt), 64'(eg));
    for (int i = 0; i < N; i++)
      if (eg[i]) begin
        e.flit = flit_of(i, seq);
        e.vc   = evc;
        q.push_back(e);
      end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0; req_head = '0; req_tail = '0; req_vc = '0;
    req_flit = '0; credit_in = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    do_reset();
    chk("rst_gnt", 64'(gnt), 0);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_out_vc", 64'(out_vc), 0);
    chk("rst_out_flit", out_flit, 0);
    chk("rst_cnt", 64'(credit_cnt), 64'(6'b100_100));
    chk("rst_locked", 64'(locked), 0);
    chk("rst_err", 64'(err), 0);

    // West single-flit packet on VC0
    step(5'b00010, 5'b00010, 5'b00010, 5'b0, 2'b00, 5'b00010, 1'b0, "w_single_gnt");
    w_flit = flit_of(1, seq);
    chk("w_out_valid", 64'(out_valid), 1);
    chk("w_cnt", 64'(credit_cnt), 64'(6'b100_011));
    chk("w_locked", 64'(locked), 0);
    step(5'b0, 5'b0, 5'b0, 5'b0, 2'b01, 5'b0, 1'b0, "idle_gnt");
    chk("idle_out_valid", 64'(out_valid), 0);
    chk("idle_out_hold", out_flit, w_flit);
    chk("idle_cnt", 64'(credit_cnt), 64'(6'b100_100));

    // East and Local 3-flit packets; East holds the lock
    do_reset();
    step(5'b10001, 5'b10001, 5'b0, 5'b0, 2'b00, 5'b00001, 1'b0, "e_head");
    chk("e_locked", 64'(locked), 1);
    step(5'b10001, 5'b10000, 5'b0, 5'b0, 2'b00, 5'b00001, 1'b0, "e_body");
    step(5'b10001, 5'b10000, 5'b00001, 5'b0, 2'b00, 5'b00001, 1'b0, "e_tail");
    chk("e_unlocked", 64'(locked), 0);
    chk("e_cnt", 64'(credit_cnt), 64'(6'b100_001));
    step(5'b10000, 5'b10000, 5'b0, 5'b0, 2'b00, 5'b10000, 1'b0, "l_head");
    chk("l_locked", 64'(locked), 1);
    chk("l_cnt0", 64'(credit_cnt), 64'(6'b100_000));
    step(5'b10000, 5'b0, 5'b0, 5'b0, 2'b01, 5'b0, 1'b0, "l_stall");
    chk("l_stall_cnt", 64'(credit_cnt), 64'(6'b100_001));
    chk("l_stall_locked", 64'(locked), 1);
    step(5'b10000, 5'b0, 5'b10000, 5'b0, 2'b01, 5'b10000, 1'b0, "l_tail");
    chk("l_tail_cnt", 64'(credit_cnt), 64'(6'b100_001));
    chk("l_unlocked", 64'(locked), 0);

    // round-robin over all inputs on VC1
    do_reset();
    step(5'b11111, 5'b11111, 5'b11111, 5'b11111, 2'b00, 5'b00001, 1'b1, "rr_e");
    chk("rr_cnt", 64'(credit_cnt), 64'(6'b011_100));
    for (int k = 0; k < 5; k++) begin
      step(5'b11111, 5'b11111, 5'b11111, 5'b11111, 2'b10,
           5'(1 << ((k + 1) % 5)), 1'b1, $sformatf("rr_%0d", k));
      chk($sformatf("rr_cnt_%0d", k), 64'(credit_cnt), 64'(6'b011_100));
    end

    // North 6-flit packet runs out of credits on VC0
    do_reset();
    for (int k = 0; k < 4; k++)
      step(5'b01000, (k == 0) ? 5'b01000 : 5'b0, 5'b0, 5'b0, 2'b00, 5'b01000, 1'b0,
           $sformatf("n_flit%0d", k));
    chk("n_cnt0", 64'(credit_cnt), 64'(6'b100_000));
    step(5'b01010, 5'b00010, 5'b0, 5'b0, 2'b00, 5'b0, 1'b0, "n_stall");
    chk("n_stall_locked", 64'(locked), 1);
    chk("n_stall_cnt", 64'(credit_cnt), 64'(6'b100_000));
    step(5'b01000, 5'b0, 5'b0, 5'b0, 2'b01, 5'b0, 1'b0, "n_credit");
    chk("n_credit_cnt", 64'(credit_cnt), 64'(6'b100_001));
    step(5'b01000, 5'b0, 5'b0, 5'b0, 2'b00, 5'b01000, 1'b0, "n_release");
    chk("n_release_cnt", 64'(credit_cnt), 64'(6'b100_000));
    step(5'b01000, 5'b0, 5'b01000, 5'b0, 2'b00, 5'b0, 1'b0, "n_tail_stall");
    chk("n_tail_stall_locked", 64'(locked), 1);
    step(5'b01000, 5'b0, 5'b01000, 5'b0, 2'b01, 5'b0, 1'b0, "n_tail_credit");
    step(5'b01000, 5'b0, 5'b01000, 5'b0, 2'b00, 5'b01000, 1'b0, "n_tail");
    chk("n_unlocked", 64'(locked), 0);

    // simultaneous transfer+credit, then credit at full
    do_reset();
    step(5'b00001, 5'b00001, 5'b00001, 5'b0, 2'b00, 5'b00001, 1'b0, "c_e1");
    step(5'b00001, 5'b00001, 5'b00001, 5'b0, 2'b00, 5'b00001, 1'b0, "c_e2");
    step(5'b00001, 5'b00001, 5'b00001, 5'b0, 2'b01, 5'b00001, 1'b0, "c_both");
    chk("c_both_cnt", 64'(credit_cnt), 64'(6'b100_010));
    step(5'b0, 5'b0, 5'b0, 5'b0, 2'b01, 5'b0, 1'b0, "c_ret1");
    step(5'b0, 5'b0, 5'b0, 5'b0, 2'b01, 5'b0, 1'b0, "c_ret2");
    chk("c_err_before", 64'(err), 0);
    step(5'b0, 5'b0, 5'b0, 5'b0, 2'b01, 5'b0, 1'b0, "c_overflow");
    chk("c_full_cnt", 64'(credit_cnt), 64'(6'b100_100));
    chk("c_err", 64'(err), 64'(ERR_EN));

    // reset in the middle of South's packet
    do_reset();
    chk("m_err_clr", 64'(err), 0);
    step(5'b00100, 5'b00100, 5'b0, 5'b00100, 2'b00, 5'b00100, 1'b1, "s_head");
    step(5'b00100, 5'b0, 5'b0, 5'b00100, 2'b00, 5'b00100, 1'b1, "s_body");
    chk("s_cnt", 64'(credit_cnt), 64'(6'b010_100));
    do_reset();
    chk("m_locked", 64'(locked), 0);
    chk("m_cnt", 64'(credit_cnt), 64'(6'b100_100));
    chk("m_out_valid", 64'(out_valid), 0);
    step(5'b00010, 5'b00010, 5'b00010, 5'b0, 2'b00, 5'b00010, 1'b0, "m_w_gnt");
    chk("m_w_cnt", 64'(credit_cnt), 64'(6'b100_011));
    step(5'b0, 5'b0, 5'b0, 5'b0, 2'b00, 5'b0, 1'b0, "m_idle");
    @(negedge clk);
    #1;
    chk("q_drained", 64'(q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
